// File: rtl/pkt_commit_pkg.sv
// Shared types for the commit-on-EOP packet buffer.
package pkt_commit_pkg;

    localparam int unsigned PKT_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_PKT  = 2'd1,
        DISCARD = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic                      eop;
        logic [PKT_DATA_W_DEF-1:0] data;
    } mem_word_t;

endpackage

// File: rtl/pkt_commit_ram.sv
// Simple dual-port RAM, one write and one registered read port; array is not reset.
module pkt_commit_ram #(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is reset so the output is deterministic after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rdata <= '0;
        else if (clr) rdata <= '0;
        else if (re)  rdata <= mem[raddr];
    end

endmodule

// File: rtl/pkt_commit_fifo.sv
// Store-and-forward packet buffer: beats become readable only once their packet's EOP commits.
// Optional drop statistics counter enabled by defining PKT_CMT_DROP_STATS_EN.
module pkt_commit_fifo
    import pkt_commit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned THR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  hw_rst,
    input  logic                  sw_rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_sop,
    input  logic                  wr_eop,
    input  logic                  wr_drop,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_eop,
    output logic                  rd_valid,
    input  logic [THR_WIDTH-1:0]  af_thresh,
    input  logic [THR_WIDTH-1:0]  ae_thresh,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   wr_lvl,
    output logic [ADDR_WIDTH:0]   pkt_cnt,
    output logic                  overflow,
    output logic                  underflow,
`ifdef PKT_CMT_DROP_STATS_EN
    output logic [15:0]           drop_cnt,
`endif
    output logic                  pkt_err
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    // Local equivalent of mem_word_t sized by DATA_WIDTH.
    typedef struct packed {
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    wr_state_e       state, state_n;
    logic [PW-1:0]   wr_ptr_spec, wr_ptr_cmt, rd_ptr;
    logic [PW-1:0]   spec_n, cmt_n, waddr, cmt_lvl;
    logic            we, commit, drop_evt, err_n, ovf_n, rd_fire, pop_eop;
    word_t           wword, rword;

    assign wr_lvl       = wr_ptr_spec - rd_ptr;
    assign cmt_lvl      = wr_ptr_cmt - rd_ptr;
    assign full         = (wr_lvl == PW'(DEPTH));
    assign empty        = (rd_ptr == wr_ptr_cmt);
    assign almost_full  = (wr_lvl >= PW'(DEPTH) - PW'(af_thresh));
    assign almost_empty = (cmt_lvl <= PW'(ae_thresh));
    assign rd_fire      = rd_en && !empty;
    assign pop_eop      = rd_valid && rd_eop;
    assign wword        = '{eop: wr_eop, data: wr_data};
    assign rd_data      = rword.data;
    assign rd_eop       = rword.eop;

    // Write FSM: speculative writes, commit on EOP, rewind on drop/overflow/abort.
    always_comb begin
        state_n  = state;
        spec_n   = wr_ptr_spec;
        cmt_n    = wr_ptr_cmt;
        we       = 1'b0;
        waddr    = wr_ptr_spec;
        commit   = 1'b0;
        drop_evt = 1'b0;
        err_n    = 1'b0;
        ovf_n    = 1'b0;
        if (wr_drop) begin
            spec_n   = wr_ptr_cmt;
            state_n  = (state == IN_PKT && !wr_eop) ? DISCARD : IDLE;
            drop_evt = (state == IN_PKT);
        end else if (wr_valid && full) begin
            ovf_n    = 1'b1;
            spec_n   = wr_ptr_cmt;
            state_n  = wr_eop ? IDLE : DISCARD;
            drop_evt = (state == IN_PKT);
        end else if (wr_valid) begin
            case (state)
                IDLE: begin
                    if (wr_sop) begin
                        we     = 1'b1;
                        spec_n = wr_ptr_spec + PW'(1);
                        if (wr_eop) begin
                            cmt_n  = wr_ptr_spec + PW'(1);
                            commit = 1'b1;
                        end else begin
                            state_n = IN_PKT;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
                IN_PKT: begin
                    we = 1'b1;
                    if (wr_sop) begin
                        // Abort the open packet and restart it at the committed pointer.
                        err_n    = 1'b1;
                        drop_evt = 1'b1;
                        waddr    = wr_ptr_cmt;
                        spec_n   = wr_ptr_cmt + PW'(1);
                    end else begin
                        spec_n   = wr_ptr_spec + PW'(1);
                    end
                    if (wr_eop) begin
                        cmt_n   = spec_n;
                        commit  = 1'b1;
                        state_n = IDLE;
                    end
                end
                DISCARD: begin
                    if (wr_eop) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, pointers, status pulses and the committed-packet count.
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            state       <= IDLE;
            wr_ptr_spec <= '0;
            wr_ptr_cmt  <= '0;
            rd_ptr      <= '0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            pkt_err     <= 1'b0;
            pkt_cnt     <= '0;
        end else if (sw_rst) begin
            state       <= IDLE;
            wr_ptr_spec <= '0;
            wr_ptr_cmt  <= '0;
            rd_ptr      <= '0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            pkt_err     <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            state       <= state_n;
            wr_ptr_spec <= spec_n;
            wr_ptr_cmt  <= cmt_n;
            if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
            rd_valid    <= rd_fire;
            overflow    <= ovf_n;
            underflow   <= rd_en && empty;
            pkt_err     <= err_n;
            // The popped beat's eop is known once it leaves the read register.
            case ({commit, pop_eop})
                2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

`ifdef PKT_CMT_DROP_STATS_EN
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst)                             drop_cnt <= '0;
        else if (sw_rst)                         drop_cnt <= '0;
        else if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
`endif

    pkt_commit_ram #(
        .WIDTH      (DATA_WIDTH + 1),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (hw_rst),
        .clr   (sw_rst),
        .we    (we),
        .waddr (waddr[ADDR_WIDTH-1:0]),
        .wdata (wword),
        .re    (rd_fire),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (rword)
    );

endmodule

// File: doc/pkt_commit_fifo.md
Name: pkt_commit_fifo

Overview:
Parametrised store-and-forward packet buffer, next generation of the ingress internal buffer.
- Write side accepts packet beats speculatively. A packet becomes visible to the read side only on its EOP beat (commit).
- Drops, overflow and aborted packets rewind to the last committed pointer, so no beat count is needed from upstream.
- Sits between the packet parser and the egress scheduler.

Parameters:
DATA_WIDTH, 32, payload width per beat
DEPTH, 1024, entries; power of two, >= 4
ADDR_WIDTH, $clog2(DEPTH), memory address width; pointers are ADDR_WIDTH+1 bits
THR_WIDTH, 8, width of almost-full/almost-empty threshold inputs

Ports:
clk  in  1  clock
hw_rst  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous active-high soft reset, same effect as hw_rst
wr_valid  in  1  write beat present
wr_data  in  DATA_WIDTH  write payload
wr_sop  in  1  first beat of packet
wr_eop  in  1  last beat of packet
wr_drop  in  1  discard current uncommitted packet
rd_en  in  1  pop one beat
rd_data  out  DATA_WIDTH  read payload
rd_eop  out  1  EOP flag stored with beat
rd_valid  out  1  rd_data/rd_eop valid
af_thresh  in  THR_WIDTH  almost-full margin
ae_thresh  in  THR_WIDTH  almost-empty margin
full  out  1  speculative level == DEPTH
empty  out  1  no committed beats
almost_full  out  1  wr_lvl >= DEPTH - af_thresh
almost_empty  out  1  cmt_lvl <= ae_thresh
wr_lvl  out  ADDR_WIDTH+1  wr_ptr_spec - rd_ptr
pkt_cnt  out  ADDR_WIDTH+1  committed packets not fully read
overflow  out  1  1-cycle pulse: wr_valid while full
underflow  out  1  1-cycle pulse: rd_en while empty
pkt_err  out  1  1-cycle pulse: SOP inside packet, or EOP/mid-packet beat with no SOP

Behaviour:
- Memory: DATA_WIDTH+1 bits wide (payload + eop).
- Pointers: wr_ptr_spec, wr_ptr_cmt, rd_ptr, each ADDR_WIDTH+1 bits. All arithmetic is modulo 2^(ADDR_WIDTH+1).
- Reset (hw_rst low or sw_rst high): all pointers 0; FSM to IDLE; rd_valid, rd_eop, overflow, underflow, pkt_err = 0; rd_data = 0; pkt_cnt = 0. Consequently empty=1, full=0, almost_empty=1. A partial packet is lost.
- Write FSM states IDLE, IN_PKT, DISCARD. A beat is accepted when wr_valid && !full && state != DISCARD && !wr_drop.
  - IDLE:
    - wr_valid && wr_sop: write; if also wr_eop, commit and stay IDLE, else go to IN_PKT.
    - wr_valid without wr_sop: pkt_err pulse, beat ignored.
  - IN_PKT:
    - accepted beat increments wr_ptr_spec.
    - accepted beat with wr_eop: wr_ptr_cmt <= wr_ptr_spec+1, pkt_cnt+1, go to IDLE.
    - wr_sop: pkt_err pulse, wr_ptr_spec <= wr_ptr_cmt, then the beat is treated as a new SOP (written at the old wr_ptr_cmt).
  - DISCARD: beats ignored until wr_valid && wr_eop, then go to IDLE.
- wr_drop (any state): wr_ptr_spec <= wr_ptr_cmt; a same-cycle beat is ignored; go to DISCARD if in IN_PKT and no wr_eop that cycle, else go to IDLE.
- Full: wr_valid && full pulses overflow next cycle, rewinds wr_ptr_spec <= wr_ptr_cmt, and enters DISCARD (IDLE if that beat had wr_eop). A packet larger than DEPTH therefore never commits.
- Read:
  - rd_en && !empty: mem[rd_ptr] is read, rd_ptr+1; rd_data/rd_eop/rd_valid are registered (latency 1).
  - rd_en && empty: underflow pulse next cycle, rd_valid=0.
  - A popped beat with eop decrements pkt_cnt. Simultaneous commit and EOP pop leave pkt_cnt unchanged.
- Flag timing: empty = (rd_ptr == wr_ptr_cmt), full = (wr_lvl == DEPTH); both combinational from registered pointers. cmt_lvl = wr_ptr_cmt - rd_ptr.
- Same-address write/read cannot occur, because rd_ptr never passes wr_ptr_cmt.
- Threshold compare is done at ADDR_WIDTH+1 bits, with thresholds zero-extended.

Optional Feature:
PKT_CMT_DROP_STATS_EN
- Defined: adds output drop_cnt [15:0], a saturating count of packets discarded by wr_drop, overflow or SOP-abort. Cleared by either reset.
- Undefined: port and logic are absent.

Decomposition:
- Package pkt_commit_pkg: wr_state_e enum (IDLE, IN_PKT, DISCARD) and a mem_word_t struct {eop, data}. Because DATA_WIDTH is a parameter, mem_word_t uses the package constant PKT_DATA_W_DEF, and the module uses a local packed equivalent when DATA_WIDTH differs.
- One sub-module: pkt_commit_ram, a simple dual-port RAM with registered read, 1 write and 1 read port, no reset on the array.

Test Plan:
1. DEPTH=16: write 3-beat packet (SOP..EOP), then rd_en x3 -> empty stays 1 until the cycle after the EOP beat; rd_valid 1 cycle after each rd_en; third beat has rd_eop=1; pkt_cnt 0->1->0.
2. Write 2 beats, assert wr_drop -> wr_lvl 2->0, empty stays 1, FSM in DISCARD; beats ignored until EOP; next SOP packet is written from the original wr_ptr_cmt.
3. Write a 20-beat packet into DEPTH=16 -> full at beat 16; overflow pulse on beat 17; wr_lvl returns to 0; no commit; pkt_cnt=0.
4. SOP at beats 1 and 3 without EOP -> pkt_err pulse at beat 3; wr_lvl=1 after beat 3; the second packet commits normally.
5. 1-beat packets written and read every cycle (steady state) -> pkt_cnt constant, no flag glitches; after 40 beats pointers have wrapped cleanly.
6. sw_rst mid-packet with 5 committed beats -> next cycle all levels 0, empty=1, rd_valid=0; rd_en gives underflow=1.
